// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg -- shared types and constants for the ROM download loader.
//   state_e      : loader sequencing states
//   SND_BASE_DEF : default byte address where the sound ROM region begins
//   DS_*         : byte-enable encodings driven on the SDRAM-style ports
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_FLUSH,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic [23:0] SND_BASE_DEF = 24'h006000;

  localparam logic [1:0] DS_WORD = 2'b11;  // both bytes
  localparam logic [1:0] DS_LO   = 2'b01;  // low byte only
  localparam logic [1:0] DS_HI   = 2'b10;  // high byte only

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if -- one toggle-handshake memory write port.
//   req : toggles once per issued access (master)
//   ack : follows req when the access completes (slave)
//   a   : word address, ds : byte enables, d : write data, we : write enable
interface rom_loader_if;
  logic        req;
  logic        ack;
  logic [22:0] a;
  logic [1:0]  ds;
  logic [15:0] d;
  logic        we;

  modport master (output req, a, ds, d, we, input  ack);
  modport slave  (input  req, a, ds, d, we, output ack);
endinterface

// File: rtl/rom_loader_port.sv
// rom_loader_port -- byte-to-word packer for one memory port.
//   in_*     : one captured byte routed to this port (valid, even, word addr, data)
//   flush_i  : download finished; push out a staged even byte once the buffer is empty
//   ack_i    : handshake acknowledge from memory
//   req_o/a_o/ds_o/d_o : toggle request and its held address/enables/data
//   issue_o  : a write is issued this cycle
//   busy_o   : request outstanding (req != ack)
//   idle_o   : nothing staged, buffered or outstanding
//   drop_o   : a byte was lost because the one-deep buffer was full
module rom_loader_port
  import rom_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        in_vld_i,
  input  logic        in_even_i,
  input  logic [22:0] in_a_i,
  input  logic [7:0]  in_b_i,
  input  logic        flush_i,
  input  logic        ack_i,
  output logic        req_o,
  output logic [22:0] a_o,
  output logic [1:0]  ds_o,
  output logic [15:0] d_o,
  output logic        issue_o,
  output logic        busy_o,
  output logic        idle_o,
  output logic        drop_o
);

  logic        req_q, req_d;
  logic [22:0] a_q, a_d;
  logic [1:0]  ds_q, ds_d;
  logic [15:0] d_q, d_d;
  logic        stg_vld_q, stg_vld_d;
  logic [22:0] stg_a_q, stg_a_d;
  logic [7:0]  stg_b_q, stg_b_d;
  logic        buf_vld_q, buf_vld_d;
  logic        buf_even_q, buf_even_d;
  logic [22:0] buf_a_q, buf_a_d;
  logic [7:0]  buf_b_q, buf_b_d;

  logic        busy, c_vld, c_even, need_wr, take;
  logic [22:0] c_a;
  logic [7:0]  c_b;

  // After reset a stale ack != 0 simply reads as busy until it returns to 0.
  assign busy = req_q != ack_i;

  always_comb begin
    // Buffered byte is always older than the incoming one, so it goes first.
    c_vld   = buf_vld_q | in_vld_i;
    c_even  = buf_vld_q ? buf_even_q : in_even_i;
    c_a     = buf_vld_q ? buf_a_q    : in_a_i;
    c_b     = buf_vld_q ? buf_b_q    : in_b_i;
    // Only an even byte into an empty stage completes without a memory write.
    need_wr = !c_even || stg_vld_q;
    take    = c_vld && (!need_wr || !busy);

    req_d      = req_q;
    a_d        = a_q;
    ds_d       = ds_q;
    d_d        = d_q;
    stg_vld_d  = stg_vld_q;
    stg_a_d    = stg_a_q;
    stg_b_d    = stg_b_q;
    buf_vld_d  = buf_vld_q;
    buf_even_d = buf_even_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    issue_o    = 1'b0;
    drop_o     = 1'b0;

    if (take) begin
      if (!c_even) begin
        issue_o = 1'b1;
        a_d     = c_a;
        if (stg_vld_q && stg_a_q == c_a) begin
          ds_d      = DS_WORD;
          d_d       = {c_b, stg_b_q};
          stg_vld_d = 1'b0;
        end else begin
          // Unrelated staged byte (if any) stays staged.
          ds_d = DS_HI;
          d_d  = {c_b, c_b};
        end
      end else begin
        if (stg_vld_q) begin
          issue_o = 1'b1;
          a_d     = stg_a_q;
          ds_d    = DS_LO;
          d_d     = {stg_b_q, stg_b_q};
        end
        stg_vld_d = 1'b1;
        stg_a_d   = c_a;
        stg_b_d   = c_b;
      end
    end else if (!c_vld && flush_i && stg_vld_q && !busy) begin
      issue_o   = 1'b1;
      a_d       = stg_a_q;
      ds_d      = DS_LO;
      d_d       = {stg_b_q, stg_b_q};
      stg_vld_d = 1'b0;
    end

    if (issue_o) req_d = ~req_q;

    if (buf_vld_q && take) buf_vld_d = 1'b0;
    if (in_vld_i) begin
      if (buf_vld_q && !take) begin
        drop_o = 1'b1;
      end else if (buf_vld_q || !take) begin
        // Either the buffer drains this cycle or the new byte cannot go yet.
        buf_vld_d  = 1'b1;
        buf_even_d = in_even_i;
        buf_a_d    = in_a_i;
        buf_b_d    = in_b_i;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      a_q        <= '0;
      ds_q       <= '0;
      d_q        <= '0;
      stg_vld_q  <= 1'b0;
      stg_a_q    <= '0;
      stg_b_q    <= '0;
      buf_vld_q  <= 1'b0;
      buf_even_q <= 1'b0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
    end else begin
      req_q      <= req_d;
      a_q        <= a_d;
      ds_q       <= ds_d;
      d_q        <= d_d;
      stg_vld_q  <= stg_vld_d;
      stg_a_q    <= stg_a_d;
      stg_b_q    <= stg_b_d;
      buf_vld_q  <= buf_vld_d;
      buf_even_q <= buf_even_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
    end
  end

  assign req_o  = req_q;
  assign a_o    = a_q;
  assign ds_o   = ds_q;
  assign d_o    = d_q;
  assign busy_o = busy;
  assign idle_o = !buf_vld_q && !stg_vld_q && !busy;

endmodule

// File: rtl/rom_loader.sv
// rom_loader -- turns the ioctl byte download stream into 16-bit writes on two
// toggle-handshake ports (main ROM below SND_BASE, sound ROM above), then holds
// the core in reset for HOLD_CYCLES before flagging the ROM as loaded.
//   clk_sys, reset        : clock, async active-high reset
//   ioctl_downl/wr/addr/dout : download stream (byte per wr rising edge)
//   port1, port2          : write ports (main / sound)
//   user_reset            : external reset request
//   rom_loaded            : sticky, set once a download has completed
//   core_reset            : reset for the game core
//   overflow              : sticky, a byte was dropped
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [23:0] SND_BASE    = SND_BASE_DEF,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  rom_loader_if.master      port1,
  rom_loader_if.master      port2,
  input  logic              user_reset,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overflow
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        loaded_q, loaded_d;
  logic        wr_q, dl_q, ovf_q, core_rst_q, we_q;

  logic        cap, snd, dl_rise;
  logic [23:0] off;
  logic        p1_issue, p1_busy, p1_idle, p1_drop;
  logic        p2_issue, p2_busy, p2_idle, p2_drop;

  // Byte capture and routing; addresses with bit 24 set fall outside the map.
  assign cap     = ioctl_downl & ioctl_wr & ~wr_q & ~ioctl_addr[24];
  assign snd     = ioctl_addr[23:0] >= SND_BASE;
  assign off     = snd ? ioctl_addr[23:0] - SND_BASE : ioctl_addr[23:0];
  assign dl_rise = ioctl_downl & ~dl_q;

  rom_loader_port u_p1 (
    .clk_sys, .reset,
    .in_vld_i (cap & ~snd), .in_even_i(~off[0]), .in_a_i(off[23:1]), .in_b_i(ioctl_dout),
    .flush_i  (state_q == ST_FLUSH), .ack_i(port1.ack),
    .req_o    (port1.req), .a_o(port1.a), .ds_o(port1.ds), .d_o(port1.d),
    .issue_o  (p1_issue), .busy_o(p1_busy), .idle_o(p1_idle), .drop_o(p1_drop)
  );

  rom_loader_port u_p2 (
    .clk_sys, .reset,
    .in_vld_i (cap & snd), .in_even_i(~off[0]), .in_a_i(off[23:1]), .in_b_i(ioctl_dout),
    .flush_i  (state_q == ST_FLUSH), .ack_i(port2.ack),
    .req_o    (port2.req), .a_o(port2.a), .ds_o(port2.ds), .d_o(port2.d),
    .issue_o  (p2_issue), .busy_o(p2_busy), .idle_o(p2_idle), .drop_o(p2_drop)
  );

  // The FSM tracks overall progress; the ports run their own handshakes.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    loaded_d = loaded_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (dl_rise) state_d = ST_COLLECT;
      ST_COLLECT, ST_ISSUE, ST_WAIT_ACK: begin
        if (!ioctl_downl)                            state_d = ST_FLUSH;
        else if (p1_issue || p2_issue)               state_d = ST_ISSUE;
        else if (state_q == ST_ISSUE)                state_d = ST_WAIT_ACK;
        else if (state_q == ST_WAIT_ACK && !p1_busy && !p2_busy)
                                                     state_d = ST_COLLECT;
      end
      ST_FLUSH: if (p1_idle && p2_idle) begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
      ST_HOLD: begin
        if (dl_rise) begin
          state_d = ST_COLLECT;
        end else if (hold_q == HOLD_LAST) begin
          state_d  = ST_DONE;
          loaded_d = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      loaded_q   <= 1'b0;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      ovf_q      <= 1'b0;
      core_rst_q <= 1'b1;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      loaded_q   <= loaded_d;
      wr_q       <= ioctl_wr;
      dl_q       <= ioctl_downl;
      ovf_q      <= ovf_q | p1_drop | p2_drop;
      core_rst_q <= user_reset | ~loaded_q | ~(state_q inside {ST_DONE, ST_IDLE});
      // Registered so write-enable is low while reset is held.
      we_q       <= ioctl_downl | (state_d inside {ST_ISSUE, ST_WAIT_ACK, ST_FLUSH});
    end
  end

  assign port1.we   = we_q;
  assign port2.we   = we_q;
  assign rom_loaded = loaded_q;
  assign core_reset = core_rst_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader -- directed and randomized checks of rom_loader against a
// byte-pairing reference model; memory ports answered by delayed-ack responders.
module tb_rom_loader;

  localparam logic [23:0] SNDB = 24'h006000;
  localparam int          HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_downl, ioctl_wr, user_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_loaded, core_reset, overflow;
  logic        ack1 = 1'b0, ack2 = 1'b0;

  rom_loader_if p1 ();
  rom_loader_if p2 ();
  assign p1.ack = ack1;
  assign p2.ack = ack2;

  rom_loader #(.SND_BASE(SNDB), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1(p1.master), .port2(p2.master),
    .user_reset(user_reset), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responders: ack follows req after dlyN extra cycles.
  int dly1 = 1, dly2 = 1, cnt1 = 0, cnt2 = 0;
  always @(posedge clk_sys) begin
    if (p1.req != ack1) begin
      if (cnt1 >= dly1) begin ack1 <= p1.req; cnt1 <= 0; end
      else cnt1 <= cnt1 + 1;
    end else cnt1 <= 0;
    if (p2.req != ack2) begin
      if (cnt2 >= dly2) begin ack2 <= p2.req; cnt2 <= 0; end
      else cnt2 <= cnt2 + 1;
    end else cnt2 <= 0;
  end

  // Write capture ({a,ds,d} per req toggle) and hold-stable check while busy.
  logic [40:0] obs1[$], obs2[$], exp1[$], exp2[$];
  logic [40:0] last1 = '0, last2 = '0;
  logic        preq1 = 1'b0, preq2 = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      last1 <= '0; last2 <= '0; preq1 <= 1'b0; preq2 <= 1'b0;
    end else begin
      if (p1.req != preq1) begin
        obs1.push_back({p1.a, p1.ds, p1.d});
        last1 <= {p1.a, p1.ds, p1.d};
      end else if (p1.req != p1.ack) chk("p1_stable", {p1.a, p1.ds, p1.d}, last1);
      if (p2.req != preq2) begin
        obs2.push_back({p2.a, p2.ds, p2.d});
        last2 <= {p2.a, p2.ds, p2.d};
      end else if (p2.req != p2.ack) chk("p2_stable", {p2.a, p2.ds, p2.d}, last2);
      preq1 <= p1.req;
      preq2 <= p2.req;
    end
  end

  // Reference model: per-port staged even byte, writes in byte order.
  logic        sv[2];
  logic [22:0] sa[2];
  logic [7:0]  sb[2];

  task automatic push_exp(input int p, input logic [40:0] w);
    if (p == 1) exp2.push_back(w); else exp1.push_back(w);
  endtask

  task automatic model_byte(input logic [24:0] ad, input logic [7:0] b);
    int p; logic [23:0] off; logic [22:0] wa;
    if (ad[24]) return;
    p   = (ad[23:0] >= SNDB) ? 1 : 0;
    off = ad[23:0] - ((p == 1) ? SNDB : 24'd0);
    wa  = off[23:1];
    if (off[0]) begin
      if (sv[p] && sa[p] == wa) begin push_exp(p, {wa, 2'b11, b, sb[p]}); sv[p] = 1'b0; end
      else push_exp(p, {wa, 2'b10, b, b});
    end else begin
      if (sv[p]) push_exp(p, {sa[p], 2'b01, sb[p], sb[p]});
      sv[p] = 1'b1; sa[p] = wa; sb[p] = b;
    end
  endtask

  task automatic model_flush();
    for (int p = 0; p < 2; p++)
      if (sv[p]) begin push_exp(p, {sa[p], 2'b01, sb[p], sb[p]}); sv[p] = 1'b0; end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) sv[p] = 1'b0;
    obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete();
  endtask

  task automatic send_byte(input logic [24:0] ad, input logic [7:0] b,
                           input int gap, input int hold, input bit use_model);
    ioctl_addr = ad; ioctl_dout = b; ioctl_wr = 1'b1;
    repeat (hold) @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
    repeat (gap) @(posedge clk_sys);
    #1;
    if (use_model) model_byte(ad, b);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_n1"}, 64'(obs1.size()), 64'(exp1.size()));
    chk({tag, "_n2"}, 64'(obs2.size()), 64'(exp2.size()));
    while (obs1.size() > 0 && exp1.size() > 0) chk({tag, "_w1"}, obs1.pop_front(), exp1.pop_front());
    while (obs2.size() > 0 && exp2.size() > 0) chk({tag, "_w2"}, obs2.pop_front(), exp2.pop_front());
    obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k, r, gap;
    logic [24:0] ad, prev;
    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; user_reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_req", p1.req, 0);       chk("rst_ds", p1.ds, 0);
    chk("rst_we", p1.we, 0);         chk("rst_loaded", rom_loaded, 0);
    chk("rst_ovf", overflow, 0);     chk("rst_core", core_reset, 1);
    reset = 1'b0;

    // Directed: word pair, sound odd byte, staged even flushed at end.
    @(posedge clk_sys); #1 ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    chk("we_dl", p1.we, 1);
    send_byte(25'h0000, 8'h11, 3, 1, 1);
    send_byte(25'h0001, 8'h22, 3, 3, 1);   // wr level-high for 3 cycles
    send_byte(25'h6003, 8'hAB, 3, 1, 1);
    send_byte(25'h0004, 8'h55, 3, 1, 1);
    ioctl_downl = 1'b0;
    model_flush();
    k = 0;
    while (!(obs1.size() >= 2 && p1.req == p1.ack) && k < 200) begin @(negedge clk_sys); k++; end
    chk("drain_to", 64'(k < 200), 1);
    chk("loaded_early", rom_loaded, 0);
    k = 0;
    while (!rom_loaded && k < 100) begin @(negedge clk_sys); k++; end
    chk("hold_len", 64'(k), 64'(HOLD + 1));
    repeat (2) @(posedge clk_sys); #1;
    chk("core_done", core_reset, 0);
    chk("we_done", p1.we, 0);
    user_reset = 1'b1; #1;
    chk("ur_lat", core_reset, 0);
    @(posedge clk_sys); #1;
    chk("ur_core", core_reset, 1);
    chk("ur_loaded", rom_loaded, 1);
    user_reset = 1'b0;
    chk("d27", (obs1.size() > 0) ? obs1[0] : '0, {23'd0, 2'b11, 16'h2211});
    chk("d29", (obs1.size() > 1) ? obs1[1] : '0, {23'd2, 2'b01, 16'h5555});
    chk("d28", (obs2.size() > 0) ? obs2[0] : '0, {23'd1, 2'b10, 16'hABAB});
    cmp_writes("dir");

    // Overflow: slow ack, second byte buffered, third dropped.
    dly1 = 20;
    @(posedge clk_sys); #1 ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    chk("redl_core", core_reset, 1);
    chk("redl_loaded", rom_loaded, 1);
    send_byte(25'h0001, 8'hC1, 2, 1, 1);
    send_byte(25'h0003, 8'hC3, 2, 1, 1);
    send_byte(25'h0005, 8'hC5, 2, 1, 0);
    chk("ovf_set", overflow, 1);
    ioctl_downl = 1'b0;
    k = 0;
    while (core_reset && k < 300) begin @(negedge clk_sys); k++; end
    chk("ovf_done_to", 64'(k < 300), 1);
    cmp_writes("ovf");

    // Reset while a request is outstanding.
    dly1 = 10;
    @(posedge clk_sys); #1 ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    send_byte(25'h0009, 8'h77, 2, 1, 0);
    chk("pre_busy", 64'(p1.req != p1.ack), 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    chk("mr_req", p1.req, 0);        chk("mr_a", p1.a, 0);
    chk("mr_ds", p1.ds, 0);          chk("mr_d", p1.d, 0);
    chk("mr_we", p1.we, 0);          chk("mr_loaded", rom_loaded, 0);
    chk("mr_ovf", overflow, 0);      chk("mr_core", core_reset, 1);
    ioctl_downl = 1'b0;
    @(posedge clk_sys); #1 reset = 1'b0;
    repeat (15) @(posedge clk_sys); #1;
    model_clear();

    // Randomized download.
    dly1 = int'($urandom_range(0, 1));
    dly2 = int'($urandom_range(0, 1));
    @(posedge clk_sys); #1 ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    prev = '0;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 6 && i > 0)  ad = prev + 25'd1;
      else if (r < 8)      ad = 25'($urandom_range(0, 63));
      else if (r < 10)     ad = 25'(SNDB) - 25'($urandom_range(1, 8));
      else if (r < 15)     ad = 25'(SNDB) + 25'($urandom_range(0, 63));
      else                 ad = 25'h1000000 | 25'($urandom_range(0, 255));
      gap = int'($urandom_range(3, 5));
      send_byte(ad, 8'($urandom), gap, 1, 1);
      prev = ad;
    end
    ioctl_downl = 1'b0;
    model_flush();
    k = 0;
    while (!rom_loaded && k < 500) begin @(negedge clk_sys); k++; end
    chk("rnd_loaded", rom_loaded, 1);
    chk("rnd_ovf", overflow, 0);
    repeat (2) @(posedge clk_sys); #1;
    chk("rnd_core", core_reset, 0);
    cmp_writes("rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter SND_BASE, default 24'h006000, byte address where the sound-board ROM region starts.
REQ-002 Parameter HOLD_CYCLES, default 16, core-reset stretch after download end.
REQ-003 Ports: clk_sys input 1, system clock; reset input 1, asynchronous active-high reset; one clock domain.
REQ-004 ioctl_downl input 1 download active; ioctl_wr input 1 byte strobe; ioctl_addr input 25 byte address; ioctl_dout input 8 byte data.
REQ-005 port1_req output 1 toggle request; port1_ack input 1 toggle ack; port1_a output 23 word address; port1_ds output 2 byte enables; port1_d output 16 data; port1_we output 1 write.
REQ-006 port2_req, port2_ack, port2_a, port2_ds, port2_d, port2_we: same as port1, sound ROM port.
REQ-007 user_reset input 1 menu/button reset; rom_loaded output 1 sticky; core_reset output 1 game reset; overflow output 1 sticky error.

Function
REQ-008 ioctl_wr rising edge (registered previous value) captures one byte; level-high ioctl_wr counts once.
REQ-009 Routing: byte address < SND_BASE -> port1, word address = addr[23:1]; otherwise port2, word address = (addr - SND_BASE)[23:1].
REQ-010 Even byte (addr[0]=0) held in low-byte staging register; matching odd byte (same word, same port) issues one word write, ds=2'b11, d={odd,even}.
REQ-011 Odd byte without matching staged even byte issues write, ds=2'b10, d={byte,byte}.
REQ-012 Even byte arriving while another even byte is staged first flushes the staged byte, ds=2'b01, d={b,b}, then stages the new byte.
REQ-013 Request handshake: port busy while req != ack; issue = toggle req with a/ds/d stable until ack equals req.
REQ-014 One-deep input buffer: byte arriving while target port busy is buffered; a further byte while buffer full is dropped and sets overflow.
REQ-015 FSM states IDLE, COLLECT, ISSUE, WAIT_ACK, FLUSH, HOLD, DONE.
REQ-016 IDLE -> COLLECT on ioctl_downl rise; COLLECT -> ISSUE when a word or partial write is due; ISSUE -> WAIT_ACK next cycle; WAIT_ACK -> COLLECT on ack match.
REQ-017 ioctl_downl fall -> FLUSH: drain buffer and staged byte (ds=2'b01) before HOLD; no byte lost on download end.
REQ-018 HOLD counts HOLD_CYCLES clocks, then sets rom_loaded and goes to DONE; DONE -> COLLECT on new ioctl_downl rise.
REQ-019 port*_we = ioctl_downl OR state in {ISSUE, WAIT_ACK, FLUSH}.
REQ-020 core_reset registered = user_reset | ~rom_loaded | state != DONE/IDLE; one-cycle latency.
REQ-021 Word address arithmetic 24-bit unsigned, truncated to 23 bits; addresses >= 2^24 ignored.
REQ-022 rom_loaded never clears except via reset; re-download asserts core_reset again.

Reset
REQ-023 reset asserted: state IDLE, req toggles 0, a/ds/d 0, we 0, staging/buffer empty, rom_loaded 0, overflow 0, core_reset 1.
REQ-024 reset mid-download abandons pending request; ack mismatch after reset is ignored until ack returns to 0.

Structure
REQ-025 Shared package holds state enum, SND_BASE default, DS encodings (DS_WORD, DS_LO, DS_HI).
REQ-026 One sub-module rom_loader_port instantiated twice: staging register, buffer, toggle handshake for one port.

Verification
REQ-027 Bytes 0x11@0x0000, 0x22@0x0001 -> port1 a=0, ds=11, d=16'h2211, one req toggle.
REQ-028 Byte 0xAB@0x6003 -> port2 a=1, ds=10, d=16'hABAB; port1 untouched.
REQ-029 Byte 0x55@0x0004 then ioctl_downl falls -> flush port1 a=2, ds=01, d=16'h5555, then rom_loaded after 16 cycles.
REQ-030 ack held 20 cycles, three bytes sent -> second buffered, third dropped, overflow=1.
REQ-031 reset pulsed during WAIT_ACK -> all outputs reset values, core_reset=1, next download works.
REQ-032 user_reset=1 after rom_loaded -> core_reset=1 next cycle, rom_loaded stays 1.
